// File: rtl/instr_byte_sequencer_if.sv
// Bus bundle for instr_byte_sequencer: byte input stream, datapath hookup and
// byte output stream.
// Handshake: a byte moves on a rising edge only when valid && ready are both
// high in that cycle; valid/byte hold until then, and ready never depends on valid.
interface instr_byte_sequencer_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [31:0] core_instr;
    logic        core_step;
    logic [31:0] core_alu_result;
    logic [31:0] core_addr;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    modport master (
        output in_valid, in_byte, core_alu_result, core_addr, out_ready,
        input  in_ready, core_instr, core_step, out_valid, out_byte, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_byte, core_alu_result, core_addr, out_ready,
        output in_ready, core_instr, core_step, out_valid, out_byte, busy, dbg_state
    );
endinterface

// File: rtl/instr_byte_sequencer.sv
// Assembles a 32-bit instruction from 4 input bytes, steps the datapath once,
// then streams the captured ALU result (and optionally the PC) back out as bytes.
module instr_byte_sequencer #(
    parameter int SEND_PC = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    instr_byte_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EXEC = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [2:0] LAST_ODX = (SEND_PC != 0) ? 3'd7 : 3'd3;

    state_t      state;
    logic [1:0]  idx;
    logic [2:0]  odx;
    logic [31:0] instr_q;
    logic [63:0] cap_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOAD;
            idx     <= 2'd0;
            odx     <= 3'd0;
            instr_q <= 32'd0;
            cap_q   <= 64'd0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        instr_q[{idx, 3'b000} +: 8] <= bus.in_byte;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= EXEC;
                    end
                end
                EXEC: begin
                    // core_addr is still the pre-step PC in this cycle
                    cap_q <= {bus.core_addr, bus.core_alu_result};
                    state <= SEND;
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (odx == LAST_ODX) begin
                            odx   <= 3'd0;
                            state <= LOAD;
                        end else begin
                            odx <= odx + 3'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready   = (state == LOAD);
    assign bus.core_step  = (state == EXEC);
    assign bus.out_valid  = (state == SEND);
    assign bus.out_byte   = (state == SEND) ? cap_q[{odx, 3'b000} +: 8] : 8'h00;
    assign bus.core_instr = instr_q;
    assign bus.busy       = !((state == LOAD) && (idx == 2'd0));
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_instr_byte_sequencer.sv
// Bench for instr_byte_sequencer: vector table, hand-written corner sequences and
// randomized instructions checked against a byte-queue model.
module tb_instr_byte_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        out_ready = 1'b0;
    logic [31:0] alu_val = 32'h0;
    logic [31:0] pc_val = 32'h0;

    instr_byte_sequencer_if if0 ();
    instr_byte_sequencer_if if1 ();

    instr_byte_sequencer #(.SEND_PC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    instr_byte_sequencer #(.SEND_PC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    assign if0.in_valid        = in_valid & ~sel;
    assign if1.in_valid        = in_valid & sel;
    assign if0.out_ready       = out_ready & ~sel;
    assign if1.out_ready       = out_ready & sel;
    assign if0.in_byte         = in_byte;
    assign if1.in_byte         = in_byte;
    assign if0.core_alu_result = alu_val;
    assign if1.core_alu_result = alu_val;
    assign if0.core_addr       = pc_val;
    assign if1.core_addr       = pc_val;

    logic        obs_in_ready, obs_step, obs_out_valid, obs_busy;
    logic [31:0] obs_instr;
    logic [7:0]  obs_out_byte;
    assign obs_in_ready  = sel ? if1.in_ready   : if0.in_ready;
    assign obs_step      = sel ? if1.core_step  : if0.core_step;
    assign obs_out_valid = sel ? if1.out_valid  : if0.out_valid;
    assign obs_busy      = sel ? if1.busy       : if0.busy;
    assign obs_instr     = sel ? if1.core_instr : if0.core_instr;
    assign obs_out_byte  = sel ? if1.out_byte   : if0.out_byte;

    int step_cnt = 0;
    always @(negedge clk) if (obs_step) step_cnt++;

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: result bytes little-endian, then PC bytes when the instance sends them.
    task automatic push_exp(input logic [31:0] alu, input logic [31:0] pc, input bit with_pc);
        for (int k = 0; k < 4; k++) exp_q.push_back(alu[8*k +: 8]);
        if (with_pc) for (int k = 0; k < 4; k++) exp_q.push_back(pc[8*k +: 8]);
    endtask

    // ---------------- driver ----------------
    task automatic do_instr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [31:0] exp_instr,
                            input int stall, input bit junk, input bit rand_rdy);
        logic [7:0] bs[4];
        int s0;
        int left;
        int guard;
        bit rdy;
        bs = '{b0, b1, b2, b3};
        s0 = step_cnt;
        left = stall;
        for (int i = 0; i < 4; i++) begin
            check("in_ready_load", obs_in_ready, 1);
            check("out_valid_load", obs_out_valid, 0);
            in_valid = 1'b1;
            in_byte = bs[i];
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("core_step_exec", obs_step, 1);
        check("core_instr", obs_instr, exp_instr);
        check("in_ready_exec", obs_in_ready, 0);
        check("out_valid_exec", obs_out_valid, 0);
        check("busy_exec", obs_busy, 1);
        in_valid = junk;
        in_byte = 8'($urandom);
        step();
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            rdy = (left > 0) ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            if (left > 0) left--;
            check("out_valid_send", obs_out_valid, 1);
            check("out_byte", obs_out_byte, exp_q[0]);
            check("core_instr_hold", obs_instr, exp_instr);
            check("core_step_send", obs_step, 0);
            out_ready = rdy;
            if (junk) in_byte = 8'($urandom);
            step();
            guard++;
            if (rdy) void'(exp_q.pop_front());
        end
        check("send_done", exp_q.size(), 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("in_ready_after", obs_in_ready, 1);
        check("out_valid_after", obs_out_valid, 0);
        check("out_byte_after", obs_out_byte, 0);
        check("busy_after", obs_busy, 0);
        check("core_instr_after", obs_instr, exp_instr);
        check("step_pulses", step_cnt - s0, 1);
    endtask

    task automatic feed4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_byte = w[8*i +: 8];
            step();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit          sel;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] alu, pc, exp_instr;
        int          n;
        logic [63:0] exp_seq;  // expected output bytes, first byte in the top lane
        int          stall;
        bit          junk;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] ins[3];
        logic [31:0] alus[3];
        logic [31:0] w;
        int s0;

        tbl[0] = '{1'b0, 8'h93, 8'h00, 8'h50, 8'h00, 32'h00000005, 32'h0, 32'h00500093,
                   4, 64'h05000000_00000000, 0, 1'b0};
        tbl[1] = '{1'b0, 8'h93, 8'h00, 8'h50, 8'h00, 32'h00000005, 32'h0, 32'h00500093,
                   4, 64'h05000000_00000000, 10, 1'b0};
        tbl[2] = '{1'b1, 8'h13, 8'h05, 8'hA0, 8'h00, 32'hDEADBEEF, 32'h00000008, 32'h00A00513,
                   8, 64'hEFBEADDE_08000000, 0, 1'b0};
        tbl[3] = '{1'b0, 8'h37, 8'h12, 8'h00, 8'h00, 32'h12345678, 32'h0, 32'h00001237,
                   4, 64'h78563412_00000000, 0, 1'b1};
        tbl[4] = '{1'b1, 8'h83, 8'hA2, 8'h04, 8'h01, 32'hA5A50F0F, 32'h80000004, 32'h0104A283,
                   8, 64'h0F0FA5A5_04000080, 3, 1'b1};

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_in_ready", obs_in_ready, 1);
        check("rst_core_instr", obs_instr, 0);
        check("rst_core_step", obs_step, 0);
        check("rst_out_valid", obs_out_valid, 0);
        check("rst_out_byte", obs_out_byte, 0);
        check("rst_busy", obs_busy, 0);

        for (int v = 0; v < 5; v++) begin
            sel = tbl[v].sel;
            alu_val = tbl[v].alu;
            pc_val = tbl[v].pc;
            for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(tbl[v].exp_seq[63 - 8*k -: 8]);
            do_instr(tbl[v].b0, tbl[v].b1, tbl[v].b2, tbl[v].b3, tbl[v].exp_instr,
                     tbl[v].stall, tbl[v].junk, 1'b0);
        end

        // Three back-to-back instructions with in_valid and out_ready held high.
        sel = 1'b0;
        for (int j = 0; j < 3; j++) begin
            ins[j] = $urandom;
            alus[j] = $urandom;
        end
        s0 = step_cnt;
        for (int t = 0; t < 27; t++) begin
            int j;
            int p;
            j = t / 9;
            p = t % 9;
            alu_val = alus[j];
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_byte = (p < 4) ? ins[j][8*p +: 8] : 8'($urandom);
            if (p < 4) check("b2b_in_ready", obs_in_ready, 1);
            if (p == 4) check("b2b_instr", obs_instr, ins[j]);
            check("b2b_step", obs_step, (p == 4) ? 1 : 0);
            if (p >= 5) begin
                check("b2b_out_valid", obs_out_valid, 1);
                check("b2b_out_byte", obs_out_byte, alus[j][8*(p-5) +: 8]);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_pulses", step_cnt - s0, 3);
        check("b2b_idle", obs_in_ready, 1);

        // Reset mid-LOAD, asserted together with a byte offer.
        in_valid = 1'b1;
        in_byte = 8'hAA;
        step();
        in_byte = 8'hBB;
        step();
        check("partial_busy", obs_busy, 1);
        rst_n = 1'b0;
        in_byte = 8'hCC;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("rst_load_instr", obs_instr, 0);
        check("rst_load_busy", obs_busy, 0);
        alu_val = 32'h00000030;
        push_exp(alu_val, pc_val, 1'b0);
        do_instr(8'h13, 8'h01, 8'h31, 8'h00, 32'h00310113, 0, 1'b0, 1'b0);

        // Reset during EXEC.
        feed4(32'hCAFE0013);
        check("exec_before_rst", obs_step, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_exec_step", obs_step, 0);
        check("rst_exec_out_valid", obs_out_valid, 0);
        check("rst_exec_instr", obs_instr, 0);
        check("rst_exec_in_ready", obs_in_ready, 1);

        // Reset mid-SEND, then a full instruction must start again at byte 0.
        sel = 1'b1;
        alu_val = 32'h11223344;
        pc_val = 32'h55667788;
        feed4(32'h00000013);
        out_ready = 1'b1;
        step();
        step();
        step();
        check("mid_send_valid", obs_out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        check("rst_send_out_valid", obs_out_valid, 0);
        check("rst_send_out_byte", obs_out_byte, 0);
        check("rst_send_busy", obs_busy, 0);
        alu_val = 32'h0BADF00D;
        pc_val = 32'h0000001C;
        push_exp(alu_val, pc_val, 1'b1);
        do_instr(8'h6F, 8'h00, 8'h00, 8'h00, 32'h0000006F, 0, 1'b0, 1'b0);

        // Randomized instructions on both variants.
        for (int r = 0; r < 24; r++) begin
            sel = 1'($urandom_range(0, 1));
            w = $urandom;
            alu_val = $urandom;
            pc_val = $urandom;
            push_exp(alu_val, pc_val, sel);
            do_instr(w[7:0], w[15:8], w[23:16], w[31:24], w,
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_byte_sequencer.md
INSTR_BYTE_SEQUENCER -- requirements
Module: instr_byte_sequencer

Interface
REQ-001 The block SHALL have one parameter: SEND_PC, default 0, meaning 1 = append the 4 captured PC bytes after the 4 result bytes.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  in_byte holds a valid instruction byte.
REQ-005 in_byte  input  8  instruction byte, little-endian order (byte 0 = instr[7:0]).
REQ-006 in_ready  output  1  block accepts in_byte this cycle.
REQ-007 core_instr  output  32  assembled instruction driven to the datapath.
REQ-008 core_step  output  1  one-cycle enable that advances datapath PC and register file.
REQ-009 core_alu_result  input  32  datapath ALU result, combinational from core_instr.
REQ-010 core_addr  input  32  datapath current PC.
REQ-011 out_valid  output  1  out_byte holds a valid result byte.
REQ-012 out_byte  output  8  result byte, little-endian order.
REQ-013 out_ready  input  1  consumer accepts out_byte this cycle.
REQ-014 busy  output  1  high in any state other than LOAD with byte count 0.

Function
REQ-015 The FSM SHALL have exactly three states: LOAD, EXEC, SEND.
REQ-016 In LOAD, in_ready SHALL be 1; a byte transfers when in_valid && in_ready, into byte lane idx of an instruction shift/assembly register; the 2-bit idx then increments.
REQ-017 On the transfer with idx == 3, the FSM SHALL go to EXEC on the next edge, and idx SHALL wrap to 0.
REQ-018 in_ready SHALL be 0 in EXEC and SEND; in_valid there SHALL be ignored and SHALL NOT alter the assembly register.
REQ-019 core_instr SHALL equal the assembly register at all times; it SHALL change only on LOAD byte transfers.
REQ-020 EXEC SHALL last exactly one cycle with core_step = 1; core_step SHALL be 0 in every other cycle.
REQ-021 In the EXEC cycle the block SHALL capture core_alu_result and core_addr (the pre-step PC) into an output register, then enter SEND.
REQ-022 Latency: the first out_valid SHALL assert the cycle after EXEC, i.e. 2 cycles after the 4th input byte transfer.
REQ-023 In SEND, out_valid SHALL be 1 and out_byte SHALL be byte odx of the captured word(s); a byte transfers on out_valid && out_ready and odx increments.
REQ-024 With SEND_PC = 0, SEND SHALL emit 4 bytes (result[7:0] first); with SEND_PC = 1, 8 bytes (result bytes 0-3, then PC bytes 0-3).
REQ-025 After the last byte transfer the FSM SHALL return to LOAD on the next edge with idx = 0 and odx = 0.
REQ-026 While out_ready = 0, out_valid and out_byte SHALL hold unchanged indefinitely (no drop, no timeout).
REQ-027 out_valid SHALL be 0 and out_byte SHALL be 0 outside SEND.
REQ-028 Input and output transfers SHALL never occur in the same cycle (mutually exclusive states).
REQ-029 All counters SHALL be exactly wide enough (idx 2 bits, odx 3 bits) and wrap only as specified.

Reset
REQ-030 When rst_n = 0 at a rising edge, the block SHALL enter LOAD with idx = 0, odx = 0, assembly and capture registers = 0.
REQ-031 Reset values: in_ready = 1, core_instr = 0, core_step = 0, out_valid = 0, out_byte = 0, busy = 0.
REQ-032 Reset mid-LOAD or mid-SEND SHALL discard partial bytes; reset during EXEC SHALL drive core_step = 0 from that edge on and SHALL NOT capture.
REQ-033 Reset SHALL take precedence over any simultaneous in_valid/out_ready transfer.

Verification
REQ-034 Bytes 0x93,0x00,0x50,0x00 (addi x1,x0,5), stub core_alu_result = 0x00000005, out_ready = 1 -> core_instr = 0x00500093, one core_step pulse, outputs 0x05,0x00,0x00,0x00, then in_ready = 1.
REQ-035 Same stimulus, out_ready held 0 for 10 cycles after EXEC -> out_valid = 1, out_byte = 0x05 stable all 10 cycles, then 4 bytes emitted in order.
REQ-036 Two bytes sent, rst_n = 0 one cycle, then bytes 0x13,0x01,0x31,0x00 -> core_instr = 0x00310113, no stale bytes, exactly one core_step.
REQ-037 SEND_PC = 1, core_addr = 0x00000008, core_alu_result = 0xDEADBEEF -> outputs EF,BE,AD,DE,08,00,00,00.
REQ-038 in_valid held 1 during EXEC/SEND with changing in_byte -> core_instr unchanged until SEND completes; next instruction's byte 0 taken only in LOAD.
REQ-039 Three back-to-back instructions with in_valid and out_ready always 1 -> exactly three core_step pulses, each 1 cycle, 9 cycles per instruction (4 load + 1 exec + 4 send).
